// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: power-up reset sequencing of PHY, MAC and user logic after MMCM lock.
// Define SEQ_WATCHDOG_EN to retry PHY reset when phyReady never arrives.
module clk_rst_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 64,
    parameter int unsigned PHY_RST_CYCLES     = 1250,
    parameter int unsigned MAC_SETTLE_CYCLES  = 256,
    parameter int unsigned PHY_TIMEOUT_CYCLES = 62500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkLocked,
    input  logic       phyReady,
    input  logic       swRstReq,
    output logic       phyRstN,
    output logic       macRst,
    output logic       userRst,
    output logic       seqDone,
    output logic [2:0] seqState,
    output logic [3:0] retryCnt
);
    if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65535 ||
        PHY_RST_CYCLES < 1 || PHY_RST_CYCLES > 65535 ||
        MAC_SETTLE_CYCLES < 1 || MAC_SETTLE_CYCLES > 65535 ||
        PHY_TIMEOUT_CYCLES < 1 || PHY_TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("clk_rst_sequencer: all cycle parameters must be in 1..65535");
    end

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        LOCK_STABLE = 3'd1,
        PHY_RST     = 3'd2,
        PHY_WAIT    = 3'd3,
        MAC_REL     = 3'd4,
        USER_REL    = 3'd5,
        RUN         = 3'd6
    } state_t;

    localparam logic [15:0] LS_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] PR_LAST = 16'(PHY_RST_CYCLES - 1);
    localparam logic [15:0] MS_LAST = 16'(MAC_SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  lock_q, lock_d, ready_q, ready_d;
    logic        phy_rst_n_q, phy_rst_n_d, mac_rst_q, mac_rst_d;
    logic        user_rst_q, user_rst_d, seq_done_q, seq_done_d;
    logic        enter, lock_sync, ready_sync;

    assign lock_sync  = lock_q[1];
    assign ready_sync = ready_q[1];

`ifdef SEQ_WATCHDOG_EN
    localparam logic [15:0] TO_LAST = 16'(PHY_TIMEOUT_CYCLES - 1);
    logic [3:0] retry_q, retry_d;
    assign retryCnt = retry_q;
`else
    assign retryCnt = 4'd0;
`endif

    always_comb begin
        lock_d  = {lock_q[0], clkLocked};
        ready_d = {ready_q[0], phyReady};
        state_d = state_q;
        enter   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        retry_d = retry_q;
`endif
        // Abort paths first: lock loss beats software restart beats PHY drop.
        if (state_q > RUN || (state_q != WAIT_LOCK && !lock_sync)) begin
            state_d = WAIT_LOCK;
            enter   = 1'b1;
        end else if (state_q != WAIT_LOCK && swRstReq) begin
            state_d = PHY_RST;
            enter   = 1'b1;
        end else if (state_q >= MAC_REL && !ready_sync) begin
            state_d = PHY_RST;
            enter   = 1'b1;
        end else begin
            case (state_q)
                WAIT_LOCK: if (lock_sync) begin
                    state_d = LOCK_STABLE;
                    enter   = 1'b1;
                end
                LOCK_STABLE: if (cnt_q == LS_LAST) begin
                    state_d = PHY_RST;
                    enter   = 1'b1;
                end
                PHY_RST: if (cnt_q == PR_LAST) begin
                    state_d = PHY_WAIT;
                    enter   = 1'b1;
                end
                PHY_WAIT: if (ready_sync) begin
                    state_d = MAC_REL;
                    enter   = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d = PHY_RST;
                    enter   = 1'b1;
                    retry_d = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;
`endif
                end
                MAC_REL: if (cnt_q == MS_LAST) begin
                    state_d = USER_REL;
                    enter   = 1'b1;
                end
                USER_REL: begin
                    state_d = RUN;
                    enter   = 1'b1;
                end
                RUN: state_d = RUN;
                default: begin
                    state_d = WAIT_LOCK;
                    enter   = 1'b1;
                end
            endcase
        end
        cnt_d       = enter ? 16'd0 : cnt_q + 16'd1;
        phy_rst_n_d = state_d >= PHY_WAIT;
        mac_rst_d   = state_d <= PHY_WAIT;
        user_rst_d  = state_d <= MAC_REL;
        seq_done_d  = state_d == RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= 16'd0;
            lock_q      <= 2'b00;
            ready_q     <= 2'b00;
            phy_rst_n_q <= 1'b0;
            mac_rst_q   <= 1'b1;
            user_rst_q  <= 1'b1;
            seq_done_q  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            retry_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            ready_q     <= ready_d;
            phy_rst_n_q <= phy_rst_n_d;
            mac_rst_q   <= mac_rst_d;
            user_rst_q  <= user_rst_d;
            seq_done_q  <= seq_done_d;
`ifdef SEQ_WATCHDOG_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign phyRstN  = phy_rst_n_q;
    assign macRst   = mac_rst_q;
    assign userRst  = user_rst_q;
    assign seqDone  = seq_done_q;
    assign seqState = state_q;
endmodule
